// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: token classification, 8b decode and word-alignment lock FSM.
// Two-stage pipeline; outputs are blanked whenever alignment is not established.
module tmds_rx_decoder #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 16,
  parameter int LOSS_LEN   = 4096
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst,
  input  logic       I_vld,
  input  logic [9:0] I_word,
  output logic       O_de,
  output logic [1:0] O_c,
  output logic [7:0] O_data,
  output logic       O_vld,
  output logic       O_locked,
  output logic       O_bitslip
);

  localparam logic [7:0]  RUN_MAX    = 8'(CTRL_RUN);
  localparam logic [15:0] SEARCH_MAX = 16'(SEARCH_LEN);
  localparam logic [15:0] LOSS_MAX   = 16'(LOSS_LEN);
  localparam logic [7:0]  WAIT_LAST  = 8'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {SEARCH, SLIPWAIT, LOCKED} state_t;

  state_t      state;
  logic        tok_hit;
  logic [1:0]  tok_c;
  logic [7:0]  d;
  logic [7:0]  dec;
  logic        s1_vld;
  logic        s1_ctrl;
  logic [1:0]  s1_c;
  logic [7:0]  s1_data;
  logic [7:0]  run_cnt;
  logic [7:0]  run_nx;
  logic [7:0]  wait_cnt;
  logic [15:0] search_cnt;
  logic [15:0] loss_cnt;
  logic [15:0] search_inc;
  logic [15:0] loss_inc;

  always_comb begin
    tok_hit = 1'b1;
    tok_c   = 2'b00;
    case (I_word)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
    d      = I_word[9] ? ~I_word[7:0] : I_word[7:0];
    dec    = 8'd0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = I_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Run of consecutive control tokens; idle cycles leave it untouched.
  always_comb begin
    run_nx = 8'd0;
    if (!s1_vld) begin
      run_nx = run_cnt;
    end else if (s1_ctrl) begin
      run_nx = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 8'd1;
    end
  end

  assign search_inc = search_cnt + 16'd1;
  assign loss_inc   = loss_cnt + 16'd1;

  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      s1_vld  <= 1'b0;
      s1_ctrl <= 1'b0;
      s1_c    <= 2'b00;
      s1_data <= 8'd0;
      O_vld   <= 1'b0;
      O_de    <= 1'b0;
      O_c     <= 2'b00;
      O_data  <= 8'd0;
    end else begin
      s1_vld  <= I_vld;
      s1_ctrl <= tok_hit;
      s1_c    <= tok_c;
      s1_data <= dec;
      O_vld   <= s1_vld;
      if (!O_locked) begin
        O_de   <= 1'b0;
        O_c    <= 2'b00;
        O_data <= 8'd0;
      end else if (s1_vld) begin
        if (s1_ctrl) begin
          O_de <= 1'b0;
          O_c  <= s1_c;
        end else begin
          O_de   <= 1'b1;
          O_data <= s1_data;
        end
      end
    end
  end

  // Lock wins over a coincident search timeout.
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      state      <= SEARCH;
      run_cnt    <= 8'd0;
      search_cnt <= 16'd0;
      loss_cnt   <= 16'd0;
      wait_cnt   <= 8'd0;
      O_locked   <= 1'b0;
      O_bitslip  <= 1'b0;
    end else begin
      O_bitslip <= 1'b0;
      case (state)
        SEARCH: if (s1_vld) begin
          if (run_nx == RUN_MAX) begin
            state      <= LOCKED;
            O_locked   <= 1'b1;
            run_cnt    <= run_nx;
            search_cnt <= 16'd0;
            loss_cnt   <= 16'd0;
          end else if (search_inc == SEARCH_MAX) begin
            state      <= SLIPWAIT;
            O_bitslip  <= 1'b1;
            run_cnt    <= 8'd0;
            search_cnt <= 16'd0;
            loss_cnt   <= 16'd0;
            wait_cnt   <= 8'd0;
          end else begin
            run_cnt    <= run_nx;
            search_cnt <= search_inc;
          end
        end
        SLIPWAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= SEARCH;
            wait_cnt   <= 8'd0;
            run_cnt    <= 8'd0;
            search_cnt <= 16'd0;
            loss_cnt   <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LOCKED: if (s1_vld) begin
          if (s1_ctrl) begin
            run_cnt  <= run_nx;
            loss_cnt <= 16'd0;
          end else if (loss_inc == LOSS_MAX) begin
            state      <= SEARCH;
            O_locked   <= 1'b0;
            run_cnt    <= 8'd0;
            search_cnt <= 16'd0;
            loss_cnt   <= 16'd0;
          end else begin
            run_cnt  <= run_nx;
            loss_cnt <= loss_inc;
          end
        end
        default: begin
          state    <= SEARCH;
          O_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Randomized and directed bench for tmds_rx_decoder against a cycle-level reference model.
module tb_tmds_rx_decoder;

  localparam int CTRL_RUN   = 8;
  localparam int SEARCH_LEN = 2048;
  localparam int SLIP_WAIT  = 16;
  localparam int LOSS_LEN   = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [9:0] word;
  logic       de;
  logic [1:0] c;
  logic [7:0] data;
  logic       ovld;
  logic       locked;
  logic       bitslip;

  int n_checks = 0;
  int n_errors = 0;
  int bs_count = 0;
  int bs_snap;

  logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // reference model state
  int         m_mode;  // 0 search, 1 waiting after slip, 2 locked
  int         m_run, m_search, m_loss, m_wait;
  logic       q_vld;
  logic [9:0] q_word;
  logic       e_vld, e_de, e_locked, e_bs;
  logic [1:0] e_c;
  logic [7:0] e_data;

  always #5 clk = ~clk;

  tmds_rx_decoder #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_LEN(SEARCH_LEN), .SLIP_WAIT(SLIP_WAIT), .LOSS_LEN(LOSS_LEN)
  ) dut (
    .I_pxl_clk(clk), .I_rst(rst), .I_vld(vld), .I_word(word),
    .O_de(de), .O_c(c), .O_data(data), .O_vld(ovld), .O_locked(locked), .O_bitslip(bitslip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == TOK[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    int d, r, b;
    d = w[9] ? int'(~w[7:0]) & 255 : int'(w[7:0]);
    r = d & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((d >> i) ^ (d >> (i - 1))) & 1;
      if (!w[8]) b = b ^ 1;
      r = r | (b << i);
    end
    return 8'(r);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    if (tok_idx(w) >= 0) w = w ^ 10'd1;
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_search = 0; m_loss = 0; m_wait = 0;
    q_vld = 1'b0; q_word = 10'd0;
    e_vld = 1'b0; e_de = 1'b0; e_c = 2'b00; e_data = 8'd0; e_locked = 1'b0; e_bs = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [9:0] w);
    int  t, run_new;
    bit  ctrl, lk;
    t    = tok_idx(q_word);
    ctrl = (t >= 0);
    lk   = (m_mode == 2);
    e_vld = q_vld;
    if (!lk) begin
      e_de = 1'b0; e_c = 2'b00; e_data = 8'd0;
    end else if (q_vld) begin
      if (ctrl) begin e_de = 1'b0; e_c = 2'(t); end
      else begin e_de = 1'b1; e_data = ref_decode(q_word); end
    end
    e_bs = 1'b0;
    run_new = !q_vld ? m_run : (ctrl ? ((m_run + 1 > CTRL_RUN) ? CTRL_RUN : m_run + 1) : 0);
    case (m_mode)
      0: if (q_vld) begin
        m_search++;
        m_run = run_new;
        if (m_run == CTRL_RUN) begin
          m_mode = 2; m_search = 0; m_loss = 0;
        end else if (m_search == SEARCH_LEN) begin
          m_mode = 1; e_bs = 1'b1; m_run = 0; m_search = 0; m_wait = 0;
        end
      end
      1: begin
        m_wait++;
        if (m_wait == SLIP_WAIT) begin m_mode = 0; m_wait = 0; m_run = 0; m_search = 0; end
      end
      default: if (q_vld) begin
        m_run = run_new;
        if (ctrl) m_loss = 0;
        else begin
          m_loss++;
          if (m_loss == LOSS_LEN) begin m_mode = 0; m_run = 0; m_search = 0; m_loss = 0; end
        end
      end
    endcase
    e_locked = (m_mode == 2);
    q_vld  = v;
    q_word = w;
  endtask

  task automatic cyc(input logic v, input logic [9:0] w);
    vld  = v;
    word = w;
    @(posedge clk);
    model_step(v, w);
    @(negedge clk);
    check("out", {18'd0, ovld, locked, bitslip, de, c, data},
                 {18'd0, e_vld, e_locked, e_bs, e_de, e_c, e_data});
    if (bitslip) bs_count++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_outs", {18'd0, ovld, locked, bitslip, de, c, data}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int heavy;
    logic v;
    logic [9:0] w;
    rst = 1'b1; vld = 1'b0; word = 10'd0;
    model_reset();
    #12;
    check("por_outs", {18'd0, ovld, locked, bitslip, de, c, data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lock on eight c=00 tokens, then a zero data byte
    for (int i = 0; i < CTRL_RUN; i++) cyc(1'b1, TOK[0]);
    check("prelock", 32'(locked), 32'd0);
    cyc(1'b1, 10'b0100000000);
    cyc(1'b0, 10'd0);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_de", 32'(de), 32'd1);
    check("lock_data", 32'(data), 32'h00);

    // inverted data word and a c=01 token
    cyc(1'b1, 10'b1000000000);
    cyc(1'b1, TOK[1]);
    check("dec_ff", {23'd0, de, data}, {23'd0, 1'b1, 8'hFF});
    cyc(1'b0, 10'd0);
    check("tok_c01", {29'd0, de, c}, {29'd0, 1'b0, 2'b01});

    // search timeout with words streaming straight through the slip wait
    do_reset();
    bs_count = 0;
    for (int i = 0; i < 2 * SEARCH_LEN + SLIP_WAIT + 8; i++) cyc(1'b1, 10'b1000000000);
    check("slip_count", 32'(bs_count), 32'd2);

    // broken run does not lock, the next full run does
    do_reset();
    for (int i = 0; i < CTRL_RUN - 1; i++) cyc(1'b1, TOK[2]);
    cyc(1'b1, rand_data());
    for (int i = 0; i < CTRL_RUN - 1; i++) cyc(1'b1, TOK[3]);
    cyc(1'b0, 10'd0);
    cyc(1'b0, 10'd0);
    check("broken_run", 32'(locked), 32'd0);
    cyc(1'b1, TOK[3]);
    cyc(1'b0, 10'd0);
    check("run_relock", 32'(locked), 32'd1);

    // loss of lock after a long data-only stretch
    bs_snap = bs_count;
    for (int i = 0; i < LOSS_LEN; i++) cyc(1'b1, rand_data());
    cyc(1'b0, 10'd0);
    cyc(1'b0, 10'd0);
    check("loss_unlocked", 32'(locked), 32'd0);
    check("loss_de", 32'(de), 32'd0);
    check("loss_no_slip", 32'(bs_count), 32'(bs_snap));

    // asynchronous reset while locked and streaming
    for (int i = 0; i < CTRL_RUN; i++) cyc(1'b1, TOK[1]);
    for (int i = 0; i < 10; i++) cyc(1'b1, rand_data());
    check("pre_arst_locked", 32'(locked), 32'd1);
    vld = 1'b1;
    word = rand_data();
    @(posedge clk);
    model_step(vld, word);
    #2 rst = 1'b1;
    #1 check("arst_outs", {18'd0, ovld, locked, bitslip, de, c, data}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < CTRL_RUN - 1; i++) cyc(1'b1, TOK[0]);
    cyc(1'b0, 10'd0);
    cyc(1'b0, 10'd0);
    check("arst_no_lock", 32'(locked), 32'd0);
    cyc(1'b1, TOK[0]);
    cyc(1'b0, 10'd0);
    check("arst_relock", 32'(locked), 32'd1);

    // randomized segments alternating token-heavy and data-heavy traffic
    for (int s = 0; s < 60; s++) begin
      heavy = $urandom_range(0, 1);
      for (int i = 0; i < 50; i++) begin
        v = ($urandom_range(0, 4) != 0);
        if (heavy == 1 && $urandom_range(0, 9) != 0) w = TOK[$urandom_range(0, 3)];
        else w = rand_data();
        cyc(v, w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
